// File: rtl/multicycle_ctrl.sv
`default_nettype none
//==============================================================================
//  Module      : multicycle_ctrl
//  Description : Multi-cycle CPU control FSM. Steps each instruction through
//                FETCH -> DECODE -> EXEC -> MEM -> WB, issues every datapath
//                strobe, handshakes with a variable-latency memory under a
//                watchdog, traps illegal opcodes and counts retired
//                instructions.
//
//  Ports
//    clk          in   system clock, rising edge
//    reset        in   synchronous, active-high
//    ir_opcode    in   [5:0] instruction register bits [31:26]
//    mem_ready    in   completion of the current mem_req
//    mem_req      out  memory access request
//    mem_we       out  memory write (sw only)
//    mem_addr_sel out  0 = PC, 1 = ALU result
//    ir_we        out  load instruction register
//    pc_we        out  update PC
//    pc_src       out  0 = PC+1, 1 = jump target
//    alu_op       out  [1:0] 0 ADD, 1 AND, 2 OR, 3 SLT
//    alu_src_imm  out  ALU B operand: 0 = rt, 1 = immediate
//    reg_we       out  register-file write
//    reg_dst_sel  out  1 = rd (R-type), 0 = rt (I-type)
//    wb_sel       out  0 = ALU result, 1 = memory data
//    state        out  [2:0] FETCH=0 DECODE=1 EXEC=2 MEM=3 WB=4 ERROR=5
//    illegal      out  sticky: illegal opcode trapped
//    timeout      out  sticky: memory watchdog expired
//    instr_count  out  [CNT_W-1:0] retired instructions (wraps)
//
//  Revision    : 1.0  initial release
//==============================================================================
module multicycle_ctrl #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       ir_opcode,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             mem_addr_sel,
  output logic             ir_we,
  output logic             pc_we,
  output logic             pc_src,
  output logic [1:0]       alu_op,
  output logic             alu_src_imm,
  output logic             reg_we,
  output logic             reg_dst_sel,
  output logic             wb_sel,
  output logic [2:0]       state,
  output logic             illegal,
  output logic             timeout,
  output logic [CNT_W-1:0] instr_count
);

  // ---------------------------------------------------------------------------
  // Constants
  // ---------------------------------------------------------------------------
  localparam logic [5:0] c_OP_ADD  = 6'd0;
  localparam logic [5:0] c_OP_ADDI = 6'd1;
  localparam logic [5:0] c_OP_AND  = 6'd3;
  localparam logic [5:0] c_OP_ORI  = 6'd6;
  localparam logic [5:0] c_OP_LW   = 6'd8;
  localparam logic [5:0] c_OP_SW   = 6'd9;
  localparam logic [5:0] c_OP_J    = 6'd16;
  localparam logic [5:0] c_OP_SLT  = 6'd19;

  localparam logic [1:0] c_ALU_ADD = 2'd0;
  localparam logic [1:0] c_ALU_AND = 2'd1;
  localparam logic [1:0] c_ALU_OR  = 2'd2;
  localparam logic [1:0] c_ALU_SLT = 2'd3;

  // The wait counter only ever needs to reach TIMEOUT-1: at that value a
  // further idle cycle traps instead of incrementing.
  localparam int                  c_WAIT_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [c_WAIT_W-1:0] c_WAIT_LAST = c_WAIT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_ERROR  = 3'd5
  } state_t;

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  state_t              r_state;
  logic [c_WAIT_W-1:0] r_wait;
  logic                r_illegal;
  logic                r_timeout;
  logic [CNT_W-1:0]    r_instr_count;

  // ---------------------------------------------------------------------------
  // Opcode decode
  // ---------------------------------------------------------------------------
  logic w_op_add, w_op_addi, w_op_and, w_op_ori;
  logic w_op_lw, w_op_sw, w_op_j, w_op_slt;
  logic w_op_legal, w_op_rtype, w_op_mem;

  assign w_op_add   = (ir_opcode == c_OP_ADD);
  assign w_op_addi  = (ir_opcode == c_OP_ADDI);
  assign w_op_and   = (ir_opcode == c_OP_AND);
  assign w_op_ori   = (ir_opcode == c_OP_ORI);
  assign w_op_lw    = (ir_opcode == c_OP_LW);
  assign w_op_sw    = (ir_opcode == c_OP_SW);
  assign w_op_j     = (ir_opcode == c_OP_J);
  assign w_op_slt   = (ir_opcode == c_OP_SLT);
  assign w_op_legal = w_op_add | w_op_addi | w_op_and | w_op_ori |
                      w_op_lw  | w_op_sw   | w_op_j   | w_op_slt;
  assign w_op_rtype = w_op_add | w_op_and | w_op_slt;
  assign w_op_mem   = w_op_lw  | w_op_sw;

  // ALU controls as a pure function of the opcode; they are presented from
  // EXEC through WB so the datapath sees a stable operation.
  logic [1:0] w_alu_op_dec;
  logic       w_alu_imm_dec;

  always_comb begin
    w_alu_op_dec  = c_ALU_ADD;
    w_alu_imm_dec = 1'b1;
    if (w_op_add) begin
      w_alu_op_dec  = c_ALU_ADD;
      w_alu_imm_dec = 1'b0;
    end else if (w_op_and) begin
      w_alu_op_dec  = c_ALU_AND;
      w_alu_imm_dec = 1'b0;
    end else if (w_op_slt) begin
      w_alu_op_dec  = c_ALU_SLT;
      w_alu_imm_dec = 1'b0;
    end else if (w_op_ori) begin
      w_alu_op_dec  = c_ALU_OR;
      w_alu_imm_dec = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and event decode
  // ---------------------------------------------------------------------------
  state_t w_next_state;
  logic   w_retire;
  logic   w_set_illegal;
  logic   w_set_timeout;
  logic   w_wait_inc;

  always_comb begin
    w_next_state  = r_state;
    w_retire      = 1'b0;
    w_set_illegal = 1'b0;
    w_set_timeout = 1'b0;
    w_wait_inc    = 1'b0;
    unique case (r_state)
      S_FETCH: begin
        // mem_ready has priority over the watchdog in the final wait cycle.
        if (mem_ready) begin
          w_next_state = S_DECODE;
        end else if (r_wait == c_WAIT_LAST) begin
          w_next_state  = S_ERROR;
          w_set_timeout = 1'b1;
        end else begin
          w_wait_inc = 1'b1;
        end
      end
      S_DECODE: begin
        if (w_op_j) begin
          w_next_state = S_FETCH;
          w_retire     = 1'b1;
        end else if (!w_op_legal) begin
          w_next_state  = S_ERROR;
          w_set_illegal = 1'b1;
        end else begin
          w_next_state = S_EXEC;
        end
      end
      S_EXEC: begin
        w_next_state = w_op_mem ? S_MEM : S_WB;
      end
      S_MEM: begin
        if (mem_ready) begin
          if (w_op_sw) begin
            w_next_state = S_FETCH;
            w_retire     = 1'b1;
          end else begin
            w_next_state = S_WB;
          end
        end else if (r_wait == c_WAIT_LAST) begin
          w_next_state  = S_ERROR;
          w_set_timeout = 1'b1;
        end else begin
          w_wait_inc = 1'b1;
        end
      end
      S_WB: begin
        w_next_state = S_FETCH;
        w_retire     = 1'b1;
      end
      S_ERROR: begin
        w_next_state = S_ERROR;
      end
      default: begin
        // Unused encodings are treated as a fault and parked in ERROR.
        w_next_state = S_ERROR;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath strobes (combinational). Everything is forced low while reset
  // is asserted so a reset that lands mid-access never issues a write.
  // ---------------------------------------------------------------------------
  logic       w_mem_req, w_mem_we, w_mem_addr_sel, w_ir_we, w_pc_we, w_pc_src;
  logic [1:0] w_alu_op;
  logic       w_alu_src_imm, w_reg_we, w_reg_dst_sel, w_wb_sel;

  always_comb begin
    w_mem_req      = 1'b0;
    w_mem_we       = 1'b0;
    w_mem_addr_sel = 1'b0;
    w_ir_we        = 1'b0;
    w_pc_we        = 1'b0;
    w_pc_src       = 1'b0;
    w_alu_op       = c_ALU_ADD;
    w_alu_src_imm  = 1'b0;
    w_reg_we       = 1'b0;
    w_reg_dst_sel  = 1'b0;
    w_wb_sel       = 1'b0;
    if (!reset) begin
      unique case (r_state)
        S_FETCH: begin
          w_mem_req = 1'b1;
          if (mem_ready) begin
            w_ir_we = 1'b1;
            w_pc_we = 1'b1;
          end
        end
        S_DECODE: begin
          if (w_op_j) begin
            w_pc_we  = 1'b1;
            w_pc_src = 1'b1;
          end
        end
        S_EXEC: begin
          w_alu_op      = w_alu_op_dec;
          w_alu_src_imm = w_alu_imm_dec;
          w_reg_dst_sel = w_op_rtype;
          w_wb_sel      = w_op_lw;
        end
        S_MEM: begin
          w_mem_req      = 1'b1;
          w_mem_addr_sel = 1'b1;
          w_mem_we       = w_op_sw;
          w_alu_op       = w_alu_op_dec;
          w_alu_src_imm  = w_alu_imm_dec;
          w_reg_dst_sel  = w_op_rtype;
          w_wb_sel       = w_op_lw;
        end
        S_WB: begin
          w_reg_we      = 1'b1;
          w_alu_op      = w_alu_op_dec;
          w_alu_src_imm = w_alu_imm_dec;
          w_reg_dst_sel = w_op_rtype;
          w_wb_sel      = w_op_lw;
        end
        default: begin
          // ERROR and unused encodings: all strobes stay low.
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // State, watchdog, sticky flags and retire counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_FETCH;
      r_wait        <= '0;
      r_illegal     <= 1'b0;
      r_timeout     <= 1'b0;
      r_instr_count <= '0;
    end else begin
      r_state <= w_next_state;
      // Any state change restarts the watchdog, so it is always zero on
      // entry to FETCH or MEM.
      if (w_next_state != r_state) begin
        r_wait <= '0;
      end else if (w_wait_inc) begin
        r_wait <= r_wait + 1'b1;
      end
      if (w_set_illegal) begin
        r_illegal <= 1'b1;
      end
      if (w_set_timeout) begin
        r_timeout <= 1'b1;
      end
      if (w_retire) begin
        r_instr_count <= r_instr_count + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign mem_req      = w_mem_req;
  assign mem_we       = w_mem_we;
  assign mem_addr_sel = w_mem_addr_sel;
  assign ir_we        = w_ir_we;
  assign pc_we        = w_pc_we;
  assign pc_src       = w_pc_src;
  assign alu_op       = w_alu_op;
  assign alu_src_imm  = w_alu_src_imm;
  assign reg_we       = w_reg_we;
  assign reg_dst_sel  = w_reg_dst_sel;
  assign wb_sel       = w_wb_sel;
  assign state        = r_state;
  assign illegal      = r_illegal;
  assign timeout      = r_timeout;
  assign instr_count  = r_instr_count;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
`default_nettype none
//==============================================================================
//  Module      : tb_multicycle_ctrl
//  Description : Directed self-checking bench for multicycle_ctrl. Inputs are
//                changed 2 time units after a rising edge and outputs are
//                checked 1 unit later, well away from the active edge.
//  Revision    : 1.0  initial release
//==============================================================================
`timescale 1ns/1ps
module tb_multicycle_ctrl;

  logic        clk;
  logic        reset;
  logic [5:0]  ir_opcode;
  logic        mem_ready;
  logic        mem_req, mem_we, mem_addr_sel, ir_we, pc_we, pc_src;
  logic [1:0]  alu_op;
  logic        alu_src_imm, reg_we, reg_dst_sel, wb_sel;
  logic [2:0]  state;
  logic        illegal, timeout;
  logic [31:0] instr_count;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  multicycle_ctrl #(.TIMEOUT(16), .CNT_W(32)) dut (
    .clk          (clk),
    .reset        (reset),
    .ir_opcode    (ir_opcode),
    .mem_ready    (mem_ready),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr_sel (mem_addr_sel),
    .ir_we        (ir_we),
    .pc_we        (pc_we),
    .pc_src       (pc_src),
    .alu_op       (alu_op),
    .alu_src_imm  (alu_src_imm),
    .reg_we       (reg_we),
    .reg_dst_sel  (reg_dst_sel),
    .wb_sel       (wb_sel),
    .state        (state),
    .illegal      (illegal),
    .timeout      (timeout),
    .instr_count  (instr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // All strobes packed so "everything low" is a single comparison.
  logic [11:0] w_strobes;
  assign w_strobes = {mem_req, mem_we, mem_addr_sel, ir_we, pc_we, pc_src,
                      alu_op, alu_src_imm, reg_we, reg_dst_sel, wb_sel};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Advance one clock; returns 2 units after the rising edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Let combinational strobes settle after an input change.
  task automatic settle();
    #1;
  endtask

  initial begin
    reset     = 1'b1;
    ir_opcode = 6'd0;
    mem_ready = 1'b0;

    // ---------------- reset state ----------------
    tick();
    mem_ready = 1'b1;
    settle();
    chk("rst_state",   32'(state), 32'd0);
    chk("rst_illegal", 32'(illegal), 32'd0);
    chk("rst_timeout", 32'(timeout), 32'd0);
    chk("rst_count",   instr_count, 32'd0);
    chk("rst_strobes", 32'(w_strobes), 32'd0);

    // ---------------- add, zero-wait ----------------
    reset     = 1'b0;
    ir_opcode = 6'd0;
    mem_ready = 1'b1;
    settle();
    chk("add_F_state", 32'(state), 32'd0);
    chk("add_F_strb",  32'({mem_req, mem_addr_sel, ir_we, pc_we, pc_src}), 32'b10110);
    tick(); settle();
    chk("add_D_state", 32'(state), 32'd1);
    chk("add_D_pcwe",  32'(pc_we), 32'd0);
    tick(); settle();
    chk("add_E_state", 32'(state), 32'd2);
    chk("add_E_alu",   32'({alu_op, alu_src_imm}), 32'b000);
    tick(); settle();
    chk("add_W_state", 32'(state), 32'd4);
    chk("add_W_strb",  32'({reg_we, reg_dst_sel, alu_op, wb_sel}), 32'b11000);
    tick(); settle();
    chk("add_done_state", 32'(state), 32'd0);
    chk("add_count",      instr_count, 32'd1);

    // ---------------- lw, 2 wait cycles in FETCH and MEM ----------------
    ir_opcode = 6'd8;
    mem_ready = 1'b0;
    settle();
    chk("lw_F0_strb", 32'({mem_req, ir_we}), 32'b10);
    tick(); settle();
    chk("lw_F1_state", 32'(state), 32'd0);
    tick();
    mem_ready = 1'b1;
    settle();
    chk("lw_F2_state", 32'(state), 32'd0);
    chk("lw_F2_irwe",  32'(ir_we), 32'd1);
    tick();
    mem_ready = 1'b0;
    settle();
    chk("lw_D_state", 32'(state), 32'd1);
    tick(); settle();
    chk("lw_E_state", 32'(state), 32'd2);
    chk("lw_E_alu",   32'({alu_op, alu_src_imm}), 32'b001);
    tick(); settle();
    chk("lw_M0_state", 32'(state), 32'd3);
    chk("lw_M0_strb",  32'({mem_req, mem_addr_sel, mem_we, alu_src_imm}), 32'b1101);
    tick(); settle();
    chk("lw_M1_state", 32'(state), 32'd3);
    tick();
    mem_ready = 1'b1;
    settle();
    chk("lw_M2_state", 32'(state), 32'd3);
    chk("lw_M2_regwe", 32'(reg_we), 32'd0);
    tick(); settle();
    chk("lw_W_state", 32'(state), 32'd4);
    chk("lw_W_strb",  32'({reg_we, wb_sel, reg_dst_sel}), 32'b110);
    tick(); settle();
    chk("lw_done_state", 32'(state), 32'd0);
    chk("lw_count",      instr_count, 32'd2);

    // ---------------- sw, ori, j after a fresh reset ----------------
    reset = 1'b1;
    tick();
    reset     = 1'b0;
    ir_opcode = 6'd9;
    mem_ready = 1'b1;
    settle();
    chk("sw_rst_count", instr_count, 32'd0);
    chk("sw_F_memwe",   32'(mem_we), 32'd0);
    tick(); settle();
    chk("sw_D_state", 32'(state), 32'd1);
    tick(); settle();
    chk("sw_E_we", 32'({mem_we, reg_we}), 32'b00);
    tick(); settle();
    chk("sw_M_state", 32'(state), 32'd3);
    chk("sw_M_we",    32'({mem_we, reg_we, mem_addr_sel}), 32'b101);
    tick();
    ir_opcode = 6'd6;
    settle();
    chk("sw_done_state", 32'(state), 32'd0);
    chk("sw_count",      instr_count, 32'd1);
    tick(); tick(); settle();
    chk("ori_E_state", 32'(state), 32'd2);
    chk("ori_E_alu",   32'({alu_op, alu_src_imm}), 32'b101);
    tick(); settle();
    chk("ori_W_strb", 32'({reg_we, reg_dst_sel, alu_op, alu_src_imm}), 32'b10101);
    tick();
    ir_opcode = 6'd16;
    settle();
    chk("ori_count", instr_count, 32'd2);
    tick(); settle();
    chk("j_D_state", 32'(state), 32'd1);
    chk("j_D_pc",    32'({pc_we, pc_src}), 32'b11);
    tick(); settle();
    chk("j_done_state", 32'(state), 32'd0);
    chk("j_count",      instr_count, 32'd3);

    // ---------------- illegal opcode 63 ----------------
    ir_opcode = 6'd63;
    tick(); settle();
    chk("ill_D_state", 32'(state), 32'd1);
    chk("ill_D_pcwe",  32'(pc_we), 32'd0);
    tick(); settle();
    chk("ill_state", 32'(state), 32'd5);
    chk("ill_flag",  32'(illegal), 32'd1);
    for (int i = 0; i < 20; i++) begin
      mem_ready = i[0];
      settle();
      chk("ill_strobes", 32'(w_strobes), 32'd0);
      tick();
    end
    settle();
    chk("ill_hold_state", 32'(state), 32'd5);
    chk("ill_hold_count", instr_count, 32'd3);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    settle();
    chk("ill_clear_flag",  32'(illegal), 32'd0);
    chk("ill_clear_state", 32'(state), 32'd0);

    // ---------------- FETCH watchdog, 16 idle cycles ----------------
    // FETCH cycle 1 is the current cycle.
    mem_ready = 1'b0;
    for (int k = 1; k < 16; k++) begin
      tick();
    end
    settle();
    chk("to_F16_state", 32'(state), 32'd0);
    chk("to_F16_flag",  32'(timeout), 32'd0);
    tick(); settle();
    chk("to_state",   32'(state), 32'd5);
    chk("to_flag",    32'(timeout), 32'd1);
    chk("to_illegal", 32'(illegal), 32'd0);
    chk("to_memreq",  32'(mem_req), 32'd0);
    reset = 1'b1;
    tick();
    reset     = 1'b0;
    ir_opcode = 6'd0;
    settle();
    chk("to_clear_flag", 32'(timeout), 32'd0);

    // Same, but mem_ready arrives in FETCH cycle 16: no trap.
    for (int k = 1; k < 16; k++) begin
      tick();
    end
    mem_ready = 1'b1;
    settle();
    chk("nto_F16_irwe", 32'(ir_we), 32'd1);
    tick(); settle();
    chk("nto_state", 32'(state), 32'd1);
    chk("nto_flag",  32'(timeout), 32'd0);
    tick(); tick(); tick(); settle();
    chk("nto_done_state", 32'(state), 32'd0);
    chk("nto_count",      instr_count, 32'd1);

    // ---------------- reset during MEM of sw ----------------
    reset = 1'b1;
    tick();
    reset     = 1'b0;
    ir_opcode = 6'd9;
    mem_ready = 1'b1;
    tick(); tick(); tick();
    settle();
    chk("rmem_state", 32'(state), 32'd3);
    chk("rmem_memwe_pre", 32'(mem_we), 32'd1);
    reset = 1'b1;
    settle();
    chk("rmem_memwe", 32'(mem_we), 32'd0);
    chk("rmem_strobes", 32'(w_strobes), 32'd0);
    tick();
    reset = 1'b0;
    settle();
    chk("rmem_after_state", 32'(state), 32'd0);
    chk("rmem_after_count", instr_count, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  // Absolute time limit so the bench can never hang.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, observed running expected finished");
    $fatal(1, "time limit");
  end

endmodule
`default_nettype wire

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Multi-cycle control FSM for the CPU datapath; sits between the instruction register/decoder and the ALU, register file, PC and memory port.
- Steps each instruction through FETCH, DECODE, EXEC, MEM and WB, and issues all datapath strobes.
- Handshakes with a variable-latency memory and bounds every wait with a watchdog.
- Traps illegal opcodes and counts retired instructions.

Parameters:
- TIMEOUT, 16: maximum cycles a FETCH or MEM state waits for mem_ready before trapping (>=2).
- CNT_W, 32: width of the retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high
- ir_opcode  in  6  instruction register bits [31:26]
- mem_ready  in  1  memory completion for the current mem_req
- mem_req  out  1  memory access request
- mem_we  out  1  memory write (sw only)
- mem_addr_sel  out  1  0 = PC, 1 = ALU result
- ir_we  out  1  load instruction register
- pc_we  out  1  update PC
- pc_src  out  1  0 = PC+1, 1 = jump target
- alu_op  out  2  0 ADD, 1 AND, 2 OR, 3 SLT
- alu_src_imm  out  1  ALU B operand: 0 = rt, 1 = immediate
- reg_we  out  1  register-file write
- reg_dst_sel  out  1  1 = rd (R-type), 0 = rt (I-type)
- wb_sel  out  1  0 = ALU result, 1 = memory data
- state  out  3  FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, ERROR=5
- illegal  out  1  sticky: illegal opcode trapped
- timeout  out  1  sticky: memory watchdog expired
- instr_count  out  CNT_W  retired instructions

Behaviour:
- Only registered elements: state, wait counter, the ERROR flags and instr_count. All strobes are combinational from state, ir_opcode and mem_ready.
- Reset (synchronous):
  - state = FETCH; wait counter, illegal, timeout and instr_count = 0.
  - All strobes are 0 in any cycle where reset = 1.
- Opcode map: add 0, addi 1, and 3, ori 6, lw 8, sw 9, j 16, slt 19. Any other value is illegal.
- FETCH:
  - mem_req = 1, mem_addr_sel = 0.
  - In the cycle mem_ready = 1: ir_we = 1, pc_we = 1, pc_src = 0; next state is DECODE.
- DECODE (one cycle):
  - j: pc_we = 1, pc_src = 1, instruction retires; next state is FETCH.
  - Illegal opcode: next state is ERROR and illegal is set.
  - All other opcodes: next state is EXEC.
- EXEC (one cycle):
  - add/slt/and: alu_src_imm = 0, alu_op = ADD/SLT/AND respectively.
  - addi/lw/sw: alu_src_imm = 1, alu_op = ADD.
  - ori: alu_src_imm = 1, alu_op = OR.
  - lw/sw go to MEM; all others go to WB.
- MEM:
  - mem_req = 1, mem_addr_sel = 1, mem_we = 1 for sw.
  - alu_op and alu_src_imm are held at their EXEC values.
  - On mem_ready: sw retires and goes to FETCH; lw goes to WB.
- WB (one cycle):
  - reg_we = 1.
  - reg_dst_sel = 1 for add/and/slt, 0 otherwise.
  - wb_sel = 1 for lw only.
  - Instruction retires; next state is FETCH.
- alu_op, alu_src_imm, reg_dst_sel and wb_sel are held stable through WB.
- Retire: instr_count += 1 in the retire cycle and wraps modulo 2^CNT_W.
- Latency with zero-wait memory (mem_ready asserted with mem_req), measured from FETCH entry to FETCH entry:
  - j: 2 cycles.
  - R-type, I-type ALU ops and sw: 4 cycles.
  - lw: 5 cycles.
  - Each memory wait cycle adds 1.
- Watchdog:
  - The wait counter clears on entry to FETCH or MEM and increments each cycle mem_ready = 0 there.
  - When the counter reaches TIMEOUT-1 with mem_ready = 0, next state is ERROR and timeout is set.
  - If mem_ready = 1 in the same cycle, mem_ready wins and no trap occurs.
- mem_ready is ignored in any state other than FETCH and MEM.
- ERROR:
  - All strobes are 0; the state is held until reset.
  - illegal and timeout remain set and instr_count is frozen.
- Reset mid-operation (including mid-MEM): the FSM returns to FETCH the next cycle and no write strobe is issued in the reset cycle.

Test Plan:
- Reset, then add $1,$3,$5 (opcode 0) with zero-wait memory:
  - states go 0,1,2,4,0.
  - reg_we=1, reg_dst_sel=1, alu_op=0 in WB.
  - instr_count=1 after 4 cycles.
- lw (opcode 8) with mem_ready delayed 2 cycles in both FETCH and MEM:
  - 9 cycles total.
  - mem_addr_sel=1, mem_we=0 in MEM.
  - wb_sel=1, reg_dst_sel=0 in WB.
- sw, then ori, then j:
  - sw: mem_we=1 only in MEM, no reg_we.
  - ori: alu_op=2, alu_src_imm=1.
  - j: pc_we=1, pc_src=1 in DECODE, retires in 2 cycles.
  - instr_count=3.
- Opcode 63 fetched:
  - state=5 and illegal=1 the cycle after DECODE.
  - All strobes stay 0 for 20 cycles; reset clears illegal.
- mem_ready held 0 in FETCH with TIMEOUT=16:
  - timeout=1 and state=5 after exactly 16 FETCH cycles.
  - Repeat with mem_ready=1 on cycle 16: no trap.
- reset pulsed while in MEM of sw with mem_ready=1 the same cycle:
  - no mem_we in that cycle.
  - state=0 the next cycle, instr_count=0.
